// File: rtl/circuito_checker.sv
// Response monitor for the four-input / Saida circuit: compares observed outputs
// against a programmable 16-entry expected table and keeps per-run statistics.
module circuito_checker #(
  parameter int OUT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tbl_we,
  input  logic [3:0]       tbl_addr,
  input  logic [OUT_W-1:0] tbl_data,
  input  logic             start,
  input  logic             stop,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [3:0]       vec_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [3:0]       ff_vec,
  output logic [OUT_W-1:0] ff_got,
  output logic [OUT_W-1:0] ff_exp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] tbl_q [16];
  logic [OUT_W-1:0] tbl_d [16];

  logic             stg_valid_q, stg_valid_d;
  logic [3:0]       stg_vec_q, stg_vec_d;
  logic [OUT_W-1:0] stg_got_q, stg_got_d;
  logic [OUT_W-1:0] stg_exp_q, stg_exp_d;

  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             fail_seen_q, fail_seen_d;
  logic [3:0]       ff_vec_q, ff_vec_d;
  logic [OUT_W-1:0] ff_got_q, ff_got_d;
  logic [OUT_W-1:0] ff_exp_q, ff_exp_d;
  logic             mismatch_q, mismatch_d;

  logic             accept;
  logic             clear_stats;

  assign accept = vec_valid && (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    clear_stats = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          clear_stats = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          clear_stats = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tbl_d = tbl_q;
    if (tbl_we && (state_q != S_RUN)) tbl_d[tbl_addr] = tbl_data;
  end

  // Stage 1: capture the sample and its table lookup; stage 2 updates statistics.
  always_comb begin
    stg_valid_d = accept;
    stg_vec_d   = vec_in;
    stg_got_d   = dut_out;
    stg_exp_d   = tbl_q[vec_in];
  end

  always_comb begin
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_seen_d = fail_seen_q;
    ff_vec_d    = ff_vec_q;
    ff_got_d    = ff_got_q;
    ff_exp_d    = ff_exp_q;
    mismatch_d  = 1'b0;
    // A new run discards any sample still in flight from the previous run.
    if (clear_stats) begin
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      fail_seen_d = 1'b0;
      ff_vec_d    = '0;
      ff_got_d    = '0;
      ff_exp_d    = '0;
    end else if (stg_valid_q) begin
      if (stg_got_q == stg_exp_q) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        mismatch_d = 1'b1;
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        if (!fail_seen_q) begin
          fail_seen_d = 1'b1;
          ff_vec_d    = stg_vec_q;
          ff_got_d    = stg_got_q;
          ff_exp_d    = stg_exp_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int unsigned i = 0; i < 16; i++) tbl_q[i] <= '0;
      stg_valid_q <= 1'b0;
      stg_vec_q   <= '0;
      stg_got_q   <= '0;
      stg_exp_q   <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_seen_q <= 1'b0;
      ff_vec_q    <= '0;
      ff_got_q    <= '0;
      ff_exp_q    <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      stg_valid_q <= stg_valid_d;
      stg_vec_q   <= stg_vec_d;
      stg_got_q   <= stg_got_d;
      stg_exp_q   <= stg_exp_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_seen_q <= fail_seen_d;
      ff_vec_q    <= ff_vec_d;
      ff_got_q    <= ff_got_d;
      ff_exp_q    <= ff_exp_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign vec_ready = (state_q == S_RUN);
  assign mismatch  = mismatch_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_seen = fail_seen_q;
  assign ff_vec    = ff_vec_q;
  assign ff_got    = ff_got_q;
  assign ff_exp    = ff_exp_q;

endmodule

// File: tb/tb_circuito_checker.sv
// Directed bench for circuito_checker: vector table bursts plus hand-written
// sequences for table locking, stop-with-accept, saturation and async reset.
module tb_circuito_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [2:0] tbl_data;
  logic       start, stop, vec_valid;
  logic [3:0] vec_in;
  logic [2:0] dut_out;

  logic       vec_ready, busy, done, mismatch, fail_seen;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] ff_vec;
  logic [2:0] ff_got, ff_exp;

  logic       vec_ready4, busy4, done4, mismatch4, fail_seen4;
  logic [3:0] pass_cnt4, fail_cnt4;
  logic [3:0] ff_vec4;
  logic [2:0] ff_got4, ff_exp4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  circuito_checker #(.OUT_W(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .stop(stop), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_in(vec_in), .dut_out(dut_out), .busy(busy), .done(done), .mismatch(mismatch),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
    .ff_vec(ff_vec), .ff_got(ff_got), .ff_exp(ff_exp)
  );

  circuito_checker #(.OUT_W(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .stop(stop), .vec_valid(vec_valid), .vec_ready(vec_ready4),
    .vec_in(vec_in), .dut_out(dut_out), .busy(busy4), .done(done4), .mismatch(mismatch4),
    .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4), .fail_seen(fail_seen4),
    .ff_vec(ff_vec4), .ff_got(ff_got4), .ff_exp(ff_exp4)
  );

  typedef struct {
    logic [3:0] vec;
    logic [2:0] got;
    logic       mm;
    logic [7:0] pass;
    logic [7:0] fail;
  } vec_t;

  vec_t tv [0:10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [2:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Results of record k appear two negedges after it is driven.
  task automatic burst(input int first, input int n);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("mismatch[%0d]", first + i - 2), int'(mismatch), int'(tv[first + i - 2].mm));
        chk($sformatf("pass_cnt[%0d]", first + i - 2), int'(pass_cnt), int'(tv[first + i - 2].pass));
        chk($sformatf("fail_cnt[%0d]", first + i - 2), int'(fail_cnt), int'(tv[first + i - 2].fail));
      end
      if (i < n) begin
        vec_valid = 1'b1; vec_in = tv[first + i].vec; dut_out = tv[first + i].got;
      end else begin
        vec_valid = 1'b0;
      end
    end
  endtask

  initial begin
    tv[0]  = '{4'h0, 3'b010, 1'b0, 8'd1, 8'd0};
    tv[1]  = '{4'hB, 3'b101, 1'b0, 8'd2, 8'd0};
    tv[2]  = '{4'hF, 3'b111, 1'b0, 8'd3, 8'd0};
    tv[3]  = '{4'hA, 3'b001, 1'b0, 8'd4, 8'd0};
    tv[4]  = '{4'hC, 3'b100, 1'b0, 8'd5, 8'd0};
    tv[5]  = '{4'h2, 3'b000, 1'b0, 8'd1, 8'd0};
    tv[6]  = '{4'hB, 3'b100, 1'b1, 8'd1, 8'd1};
    tv[7]  = '{4'hF, 3'b000, 1'b1, 8'd1, 8'd2};
    tv[8]  = '{4'hB, 3'b101, 1'b0, 8'd2, 8'd2};
    tv[9]  = '{4'hB, 3'b000, 1'b0, 8'd1, 8'd0};
    tv[10] = '{4'hB, 3'b101, 1'b1, 8'd1, 8'd1};

    rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    start = 1'b0; stop = 1'b0; vec_valid = 1'b0; vec_in = '0; dut_out = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(vec_ready), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    rst_n = 1'b1;

    // All-matching burst
    tbl_write(4'h0, 3'b010);
    tbl_write(4'hB, 3'b101);
    tbl_write(4'hF, 3'b111);
    tbl_write(4'hA, 3'b001);
    tbl_write(4'hC, 3'b100);
    do_start();
    chk("run_busy", int'(busy), 1);
    chk("run_ready", int'(vec_ready), 1);
    burst(0, 5);
    chk("t1_fail_seen", int'(fail_seen), 0);

    // Mixed burst with first-failure capture
    do_stop();
    chk("stop_done", int'(done), 1);
    do_start();
    chk("restart_pass", int'(pass_cnt), 0);
    burst(5, 3);
    chk("t2_fail_seen", int'(fail_seen), 1);
    chk("t2_ff_vec", int'(ff_vec), 11);
    chk("t2_ff_got", int'(ff_got), 4);
    chk("t2_ff_exp", int'(ff_exp), 5);

    // Table write during RUN is ignored
    tbl_write(4'hB, 3'b000);
    burst(8, 1);
    do_stop();
    tbl_write(4'hB, 3'b000);
    do_start();
    chk("t3_clr_pass", int'(pass_cnt), 0);
    chk("t3_clr_fail", int'(fail_cnt), 0);
    chk("t3_clr_seen", int'(fail_seen), 0);
    chk("t3_clr_ffvec", int'(ff_vec), 0);
    chk("t3_clr_ffexp", int'(ff_exp), 0);
    burst(9, 2);
    chk("t3_ff_exp", int'(ff_exp), 0);

    // stop together with a failing accept
    do_stop();
    do_start();
    @(negedge clk);
    vec_valid = 1'b1; vec_in = 4'hF; dut_out = 3'b000; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_done", int'(done), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_ready", int'(vec_ready), 0);
    @(negedge clk);
    chk("t4_fail", int'(fail_cnt), 1);
    chk("t4_mismatch", int'(mismatch), 1);
    chk("t4_pass", int'(pass_cnt), 0);
    repeat (3) @(negedge clk);
    chk("t4_fail_hold", int'(fail_cnt), 1);
    chk("t4_mm_clear", int'(mismatch), 0);
    vec_valid = 1'b0;

    // start and stop together in DONE: start wins
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", int'(busy), 1);
    chk("ss_fail_clr", int'(fail_cnt), 0);

    // Saturation: 20 matching samples
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vec_valid = 1'b1; vec_in = 4'hA; dut_out = 3'b001;
    end
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    chk("sat4_pass", int'(pass_cnt4), 15);
    chk("sat8_pass", int'(pass_cnt), 20);
    chk("sat4_fail", int'(fail_cnt4), 0);

    // Asynchronous reset mid-run
    @(negedge clk);
    vec_valid = 1'b1; vec_in = 4'hC; dut_out = 3'b000;
    repeat (2) @(negedge clk);
    vec_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_pass", int'(pass_cnt), 0);
    chk("ar_fail", int'(fail_cnt), 0);
    chk("ar_seen", int'(fail_seen), 0);
    chk("ar_ffvec", int'(ff_vec), 0);
    chk("ar_ffgot", int'(ff_got), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    @(negedge clk);
    vec_valid = 1'b1; vec_in = 4'hB; dut_out = 3'b101;
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    chk("ar_tbl_fail", int'(fail_cnt), 1);
    chk("ar_tbl_ffexp", int'(ff_exp), 0);
    chk("ar_tbl_mm", int'(mismatch), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
